// File: rtl/uart_core_if.sv
// Serial and handshake signal bundle for uart_core.
// The slave side is the UART; the master side is the user logic and line driver.
interface uart_core_if #(
   parameter int unsigned DATA_BITS = 8
) ();
   logic                 tx_valid;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_ready;
   logic                 tx;
   logic                 rx;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_parity_err;
   logic                 rx_frame_err;

   modport slave (
      input  tx_valid, tx_data, rx,
      output tx_ready, tx, rx_data, rx_valid, rx_parity_err, rx_frame_err
   );

   modport master (
      output tx_valid, tx_data, rx,
      input  tx_ready, tx, rx_data, rx_valid, rx_parity_err, rx_frame_err
   );
endinterface

// File: rtl/uart_core.sv
// Full-duplex UART: handshaked transmitter and false-start-filtered receiver
// sharing one baud divisor, with configurable width, parity and stop bits.
module uart_core #(
   parameter int unsigned CLK_HZ    = 100000,
   parameter int unsigned BAUD      = 9600,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input logic        clk,
   input logic        rst_n,
   uart_core_if.slave u_if
);
   localparam int unsigned DIV     = CLK_HZ / BAUD;
   localparam int unsigned HALF    = DIV / 2;
   localparam int unsigned CW      = $clog2(DIV);
   localparam int unsigned BW      = 4;
   localparam logic        ODD     = (PARITY == 1);
   localparam logic        HAS_PAR = (PARITY != 0);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_BREAK  = 3'd5;

   logic [2:0]           tx_state_q, tx_state_d;
   logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
   logic [BW-1:0]        tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
   logic                 tx_par_q, tx_par_d;
   logic                 tx_q, tx_d;
   logic                 tx_ready_q, tx_ready_d;
   logic                 tx_tick;

   logic                 rx_s1_q, rx_s2_q;
   logic [2:0]           rx_state_q, rx_state_d;
   logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
   logic [BW-1:0]        rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
   logic                 rx_par_q, rx_par_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 rx_perr_q, rx_perr_d;
   logic                 rx_ferr_q, rx_ferr_d;
   logic                 rx_tick;

   // Transmitter state and registered line outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= S_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         tx_par_q   <= 1'b0;
         tx_q       <= 1'b1;
         tx_ready_q <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         tx_par_q   <= tx_par_d;
         tx_q       <= tx_d;
         tx_ready_q <= tx_ready_d;
      end
   end

   // tx_d holds the level of the next bit so the line changes on the bit boundary edge
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_par_d   = tx_par_q;
      tx_d       = tx_q;
      tx_ready_d = tx_ready_q;
      tx_tick    = (tx_cnt_q == CW'(DIV - 1));
      if (tx_state_q != S_IDLE) tx_cnt_d = tx_tick ? '0 : tx_cnt_q + CW'(1);
      case (tx_state_q)
         S_IDLE: if (u_if.tx_valid && tx_ready_q) begin
            tx_state_d = S_START;
            tx_sh_d    = u_if.tx_data;
            tx_par_d   = ^u_if.tx_data ^ ODD;
            tx_d       = 1'b0;
            tx_ready_d = 1'b0;
            tx_cnt_d   = '0;
         end
         S_START: if (tx_tick) begin
            tx_state_d = S_DATA;
            tx_bit_d   = '0;
            tx_d       = tx_sh_q[0];
         end
         S_DATA: if (tx_tick) begin
            if (tx_bit_q == BW'(DATA_BITS - 1)) begin
               tx_bit_d   = '0;
               tx_state_d = HAS_PAR ? S_PARITY : S_STOP;
               tx_d       = HAS_PAR ? tx_par_q : 1'b1;
            end else begin
               tx_bit_d = tx_bit_q + BW'(1);
               tx_sh_d  = tx_sh_q >> 1;
               tx_d     = tx_sh_q[1];
            end
         end
         S_PARITY: if (tx_tick) begin
            tx_state_d = S_STOP;
            tx_d       = 1'b1;
         end
         S_STOP: if (tx_tick) begin
            if (tx_bit_q == BW'(STOP_BITS - 1)) begin
               tx_state_d = S_IDLE;
               tx_bit_d   = '0;
               tx_ready_d = 1'b1;
            end else begin
               tx_bit_d = tx_bit_q + BW'(1);
            end
         end
         default: begin
            tx_state_d = S_IDLE;
            tx_d       = 1'b1;
            tx_ready_d = 1'b1;
         end
      endcase
   end

   // Receiver state; synchroniser resets to the idle-high line level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_state_q <= S_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_par_q   <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_perr_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
      end else begin
         rx_s1_q    <= u_if.rx;
         rx_s2_q    <= rx_s1_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_par_q   <= rx_par_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_perr_q  <= rx_perr_d;
         rx_ferr_q  <= rx_ferr_d;
      end
   end

   // rx_par_q accumulates data XOR, then becomes the parity-error flag at the parity sample
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_par_d   = rx_par_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_perr_d  = rx_perr_q;
      rx_ferr_d  = rx_ferr_q;
      rx_tick    = (rx_cnt_q == CW'(DIV - 1));
      if (rx_state_q != S_IDLE && rx_state_q != S_BREAK) rx_cnt_d = rx_cnt_q + CW'(1);
      case (rx_state_q)
         S_IDLE: if (!rx_s2_q) begin
            rx_state_d = S_START;
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
         end
         S_START: if (rx_cnt_q == CW'(HALF - 1)) begin
            rx_cnt_d   = '0;
            rx_par_d   = 1'b0;
            rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
         end
         S_DATA: if (rx_tick) begin
            rx_cnt_d = '0;
            rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
            rx_par_d = rx_par_q ^ rx_s2_q;
            if (rx_bit_q == BW'(DATA_BITS - 1)) begin
               rx_bit_d   = '0;
               rx_state_d = HAS_PAR ? S_PARITY : S_STOP;
            end else begin
               rx_bit_d = rx_bit_q + BW'(1);
            end
         end
         S_PARITY: if (rx_tick) begin
            rx_cnt_d   = '0;
            rx_par_d   = rx_par_q ^ rx_s2_q ^ ODD;
            rx_state_d = S_STOP;
         end
         S_STOP: if (rx_tick) begin
            rx_cnt_d   = '0;
            rx_valid_d = 1'b1;
            rx_data_d  = rx_sh_q;
            rx_perr_d  = HAS_PAR & rx_par_q;
            rx_ferr_d  = !rx_s2_q;
            rx_state_d = rx_s2_q ? S_IDLE : S_BREAK;
         end
         S_BREAK: if (rx_s2_q) rx_state_d = S_IDLE;
         default: rx_state_d = S_IDLE;
      endcase
   end

   assign u_if.tx            = tx_q;
   assign u_if.tx_ready      = tx_ready_q;
   assign u_if.rx_data       = rx_data_q;
   assign u_if.rx_valid      = rx_valid_q;
   assign u_if.rx_parity_err = rx_perr_q;
   assign u_if.rx_frame_err  = rx_ferr_q;
endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: 8N1 transmit, 7E2 loopback, odd parity,
// break handling, false start and mid-frame reset, checked via a scoreboard.
module tb_uart_core;
   localparam int unsigned CLK_HZ = 100000;
   localparam int unsigned BAUD   = 10000;
   localparam int unsigned DIV    = CLK_HZ / BAUD;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   a_vcnt = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   uart_core_if #(.DATA_BITS(8)) a_if ();
   uart_core_if #(.DATA_BITS(7)) b_if ();
   uart_core_if #(.DATA_BITS(8)) c_if ();

   uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
      u_a (.clk(clk), .rst_n(rst_n), .u_if(a_if.slave));
   uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2))
      u_b (.clk(clk), .rst_n(rst_n), .u_if(b_if.slave));
   uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
      u_c (.clk(clk), .rst_n(rst_n), .u_if(c_if.slave));

   assign b_if.rx = b_if.tx;

   always @(posedge clk) if (a_if.rx_valid === 1'b1) a_vcnt <= a_vcnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // Drives n bits LSB first onto the rx line of instance a (0) or c (2)
   task automatic drive_bits(input int which, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         if (which == 0) a_if.rx = bits[i];
         else            c_if.rx = bits[i];
         repeat (DIV) @(posedge clk);
      end
   endtask

   task automatic wait_rx(input int which, input int budget, input string tag);
      bit         got = 1'b0;
      logic [7:0] d   = '0;
      logic       pe  = 1'b0;
      logic       fe  = 1'b0;
      exp_t       e   = '0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         case (which)
            0: if (a_if.rx_valid === 1'b1) begin
               got = 1'b1; d = a_if.rx_data; pe = a_if.rx_parity_err; fe = a_if.rx_frame_err;
            end
            1: if (b_if.rx_valid === 1'b1) begin
               got = 1'b1; d = {1'b0, b_if.rx_data}; pe = b_if.rx_parity_err; fe = b_if.rx_frame_err;
            end
            default: if (c_if.rx_valid === 1'b1) begin
               got = 1'b1; d = c_if.rx_data; pe = c_if.rx_parity_err; fe = c_if.rx_frame_err;
            end
         endcase
      end
      chk({tag, "_seen"}, 32'(got), 32'd1);
      chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) e = sb.pop_front();
      if (got) begin
         chk({tag, "_data"}, 32'(d), 32'(e.d));
         chk({tag, "_perr"}, 32'(pe), 32'(e.pe));
         chk({tag, "_ferr"}, 32'(fe), 32'(e.fe));
      end
   endtask

   initial begin
      int         n;
      int         last;
      bit         acc;
      logic [9:0] fr;
      logic [6:0] bw [3];
      bw = '{7'h55, 7'h00, 7'h7F};
      a_if.tx_valid = 1'b0; a_if.tx_data = '0; a_if.rx = 1'b1;
      b_if.tx_valid = 1'b0; b_if.tx_data = '0;
      c_if.tx_valid = 1'b0; c_if.tx_data = '0; c_if.rx = 1'b1;

      repeat (3) begin
         @(negedge clk);
         chk("rst_tx", 32'(a_if.tx), 32'd1);
         chk("rst_ready", 32'(a_if.tx_ready), 32'd1);
         chk("rst_valid", 32'(a_if.rx_valid), 32'd0);
         chk("rst_data", 32'(a_if.rx_data), 32'd0);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_tx", 32'(a_if.tx), 32'd1);
      chk("post_rst_ready", 32'(a_if.tx_ready), 32'd1);

      // 8N1 transmit of 0xA5; tx_data is changed after the accept to prove capture
      a_if.tx_data = 8'hA5; a_if.tx_valid = 1'b1;
      @(posedge clk); #1;
      a_if.tx_valid = 1'b0; a_if.tx_data = 8'hFF;
      fr = {1'b1, 8'hA5, 1'b0};
      for (int j = 0; j < 100; j++) begin
         @(negedge clk);
         chk("tx_bit", 32'(a_if.tx), 32'(fr[j / 10]));
         chk("tx_busy", 32'(a_if.tx_ready), 32'd0);
      end
      @(negedge clk);
      chk("tx_ready_ret", 32'(a_if.tx_ready), 32'd1);
      chk("tx_idle", 32'(a_if.tx), 32'd1);

      // 7E2 loopback, three back-to-back words
      fork
         begin
            n = 0; last = 0;
            b_if.tx_data = bw[0]; b_if.tx_valid = 1'b1;
            for (int w = 0; w < 3; w++) begin
               acc = 1'b0;
               for (int i = 0; i < 400 && !acc; i++) begin
                  @(posedge clk); n++;
                  if (b_if.tx_ready === 1'b1) acc = 1'b1;
               end
               chk("b_accept", 32'(acc), 32'd1);
               sb.push_back('{d: {1'b0, bw[w]}, pe: 1'b0, fe: 1'b0});
               if (w > 0) chk("b_spacing", 32'(n - last), 32'd111);
               last = n;
               #1;
               if (w < 2) b_if.tx_data = bw[w + 1];
               else       b_if.tx_valid = 1'b0;
            end
         end
         repeat (3) wait_rx(1, 600, "b_rx");
      join

      // Odd parity: 0x0F has even weight, so the correct parity bit is 1 and 0 is bad
      sb.push_back('{d: 8'h0F, pe: 1'b1, fe: 1'b0});
      fork
         drive_bits(2, 16'({1'b1, 1'b0, 8'h0F, 1'b0}), 11);
         wait_rx(2, 200, "par_bad");
      join
      repeat (DIV) @(posedge clk); #1;
      chk("par_held", 32'(c_if.rx_parity_err), 32'd1);
      sb.push_back('{d: 8'h0F, pe: 1'b0, fe: 1'b0});
      fork
         drive_bits(2, 16'({1'b1, 1'b1, 8'h0F, 1'b0}), 11);
         wait_rx(2, 200, "par_good");
      join

      // Line break: start bit followed by 30 bit times of low
      n = a_vcnt;
      sb.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
      a_if.rx = 1'b0;
      fork
         repeat (31 * DIV) @(posedge clk);
         wait_rx(0, 200, "brk");
      join
      #1;
      chk("brk_single", 32'(a_vcnt - n), 32'd1);
      chk("brk_ferr_held", 32'(a_if.rx_frame_err), 32'd1);
      a_if.rx = 1'b1;
      repeat (2 * DIV) @(posedge clk);
      sb.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b0});
      fork
         drive_bits(0, 16'({1'b1, 8'h3C, 1'b0}), 10);
         wait_rx(0, 200, "after_brk");
      join

      // 3-clock glitch must be rejected as a false start
      repeat (2 * DIV) @(posedge clk); #1;
      n = a_vcnt;
      a_if.rx = 1'b0;
      repeat (3) @(posedge clk);
      #1 a_if.rx = 1'b1;
      repeat (3 * DIV) @(posedge clk); #1;
      chk("glitch_no_valid", 32'(a_vcnt - n), 32'd0);
      chk("glitch_data_held", 32'(a_if.rx_data), 32'h3C);

      // Asynchronous reset in the middle of a transmit data bit
      @(negedge clk);
      a_if.tx_data = 8'h00; a_if.tx_valid = 1'b1;
      @(posedge clk); #1 a_if.tx_valid = 1'b0;
      repeat (25) @(negedge clk);
      chk("mid_tx_low", 32'(a_if.tx), 32'd0);
      chk("mid_tx_busy", 32'(a_if.tx_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_tx", 32'(a_if.tx), 32'd1);
      chk("async_rst_ready", 32'(a_if.tx_ready), 32'd1);
      chk("async_rst_data", 32'(a_if.rx_data), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rel_ready", 32'(a_if.tx_ready), 32'd1);
      chk("rel_tx", 32'(a_if.tx), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
